// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, BTB entry layout and the
// default BTB size used by the fetch stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int BTB_ENTRIES_DEFAULT = 16;

  // Tag is kept word-wide so the struct stays independent of BTB size;
  // unused upper tag bits are always zero and trim away in synthesis.
  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    logic [1:0] ctr;
  } btb_entry_t;

  // Two-bit saturating counter step toward the observed outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken && ctr != 2'b11) r = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) r = ctr - 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup for the fetch PC,
// clocked update from the resolving branch in MEM.
module btb
  import cpu_types_pkg::*;
#(
  parameter int         BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter logic [1:0] CTR_INIT    = 2'b10
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t lookup_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  logic  upd_taken,
  input  word_t upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] valid_q;
  word_t                  tag_q    [BTB_ENTRIES];
  word_t                  target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  word_t            lk_tag, up_tag;
  btb_entry_t       lk_entry, up_entry;
  logic             lk_hit, up_hit;

  always_comb begin
    lk_idx   = lookup_pc[IDX_W+1:2];
    up_idx   = upd_pc[IDX_W+1:2];
    lk_tag   = lookup_pc >> (IDX_W + 2);
    up_tag   = upd_pc >> (IDX_W + 2);
    lk_entry = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx],
                 target: target_q[lk_idx], ctr: ctr_q[lk_idx]};
    up_entry = '{valid: valid_q[up_idx], tag: tag_q[up_idx],
                 target: target_q[up_idx], ctr: ctr_q[up_idx]};
    lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
    up_hit      = up_entry.valid && (up_entry.tag == up_tag);
    pred_taken  = lk_hit && lk_entry.ctr[1];
    pred_target = lk_entry.target;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (upd_en && !up_hit && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // NOTE: only the valid bits are reset; tag/target/counter are don't-care
  // until valid is set, so they stay plain RAM without a reset network.
  always_ff @(posedge CLK) begin
    if (upd_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_step(up_entry.ctr, upd_taken);
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// Fetch stage: PC register, next-PC select with BTB prediction, branch
// mispredict redirect/flush and sticky halt.
module fetch_predict_unit
  import cpu_types_pkg::*;
#(
  parameter word_t      PC_INIT     = 32'h0,
  parameter int         BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter logic [1:0] CTR_INIT    = 2'b10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        enable,
  input  logic        halt,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic [31:0] pc_4,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        flush
);

  word_t pc_q, pc_next;
  logic  halted_q;
  logic  mispredict, redirect;

  btb #(.BTB_ENTRIES(BTB_ENTRIES), .CTR_INIT(CTR_INIT)) u_btb (
    .CLK         (CLK),
    .nRST        (nRST),
    .lookup_pc   (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (resolve_valid && enable && !halted_q),
    .upd_pc      (resolve_pc),
    .upd_taken   (resolve_taken),
    .upd_target  (resolve_target)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    mispredict = resolve_valid && ((resolve_taken != resolve_pred_taken) ||
                 (resolve_taken && (resolve_target != resolve_pred_target)));
    redirect   = mispredict && enable && !halted_q;
    pc_next    = pc_q;
    if (!halted_q) begin
      if (redirect)
        pc_next = resolve_taken ? resolve_target : resolve_pc + 32'd4;
      else if (ihit && enable)
        pc_next = pred_taken ? pred_target : pc_q + 32'd4;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC_INIT;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_next;
      halted_q <= halted_q || halt;
    end
  end

  assign imemaddr = pc_q;
  assign pc_4     = pc_q + 32'd4;
  assign imemREN  = !halted_q;
  assign flush    = redirect;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit with a 4-entry BTB so that 0x10 and
// 0x20 collide on index 0.
module tb_fetch_predict_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, enable, halt;
  logic [31:0] imemaddr, pc_4, pred_target;
  logic        imemREN, pred_taken, flush;
  logic        resolve_valid, resolve_taken, resolve_pred_taken;
  logic [31:0] resolve_pc, resolve_target, resolve_pred_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_predict_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(4), .CTR_INIT(2'b10)) u_dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .ihit                (ihit),
    .enable              (enable),
    .halt                (halt),
    .imemaddr            (imemaddr),
    .imemREN             (imemREN),
    .pc_4                (pc_4),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .flush               (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    resolve_valid       = 1'b1;
    resolve_pc          = pc;
    resolve_taken       = taken;
    resolve_target      = tgt;
    resolve_pred_taken  = ptaken;
    resolve_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
  endtask

  // Steer the PC to addr with a not-taken resolve at addr-4 that was predicted taken.
  task automatic redirect_to(input logic [31:0] addr);
    resolve(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    idle();
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; enable = 1'b1; halt = 1'b0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    resolve_target = '0; resolve_pred_taken = 1'b0; resolve_pred_target = '0;
    #3;
    check("rst_pc", imemaddr, 32'h0);
    check("rst_pc4", pc_4, 32'h4);
    check("rst_ren", {31'b0, imemREN}, 32'h1);
    check("rst_pred", {31'b0, pred_taken}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Sequential fetch
    ihit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("seq_pc%0d", k), imemaddr, 32'(4 * k));
      check($sformatf("seq_pred%0d", k), {31'b0, pred_taken}, 32'h0);
      step();
    end
    ihit = 1'b0;
    check("seq_end", imemaddr, 32'h10);

    // Taken branch at 0x10 allocates and redirects
    resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    check("alloc_flush", {31'b0, flush}, 32'h1);
    step();
    idle();
    check("alloc_pc", imemaddr, 32'h40);
    redirect_to(32'h10);
    check("alloc_refetch", imemaddr, 32'h10);
    check("alloc_pred", {31'b0, pred_taken}, 32'h1);
    check("alloc_tgt", pred_target, 32'h40);

    // Two in-flight not-taken resolves: 10 -> 01 -> 00
    resolve(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    check("nt1_flush", {31'b0, flush}, 32'h1);
    step();
    check("nt1_pc", imemaddr, 32'h14);
    resolve(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    check("nt2_flush", {31'b0, flush}, 32'h1);
    step();
    idle();
    check("nt2_pc", imemaddr, 32'h14);
    redirect_to(32'h10);
    check("nt_refetch_pred", {31'b0, pred_taken}, 32'h0);
    // Third not-taken, correctly predicted: no flush, counter stays at 00
    resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
    check("nt3_flush", {31'b0, flush}, 32'h0);
    step();
    idle();
    #1;
    check("nt3_hold", imemaddr, 32'h10);
    check("sat_low_pred", {31'b0, pred_taken}, 32'h0);

    // resolve_pc + 4 wraps to zero
    redirect_to(32'h0);
    check("wrap_pc", imemaddr, 32'h0);
    check("wrap_pc4", pc_4, 32'h4);

    // Stall on ihit=0, then mispredict without ihit
    redirect_to(32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d", k), imemaddr, 32'h8);
    end
    resolve(32'h34, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    idle();
    check("noihit_redir", imemaddr, 32'h80);

    // Mispredict under enable=0 is ignored until enable rises
    enable = 1'b0;
    ihit   = 1'b1;
    resolve(32'h10, 1'b1, 32'h60, 1'b0, 32'h0);
    check("stall_flush", {31'b0, flush}, 32'h0);
    step();
    check("stall_pc", imemaddr, 32'h80);
    enable = 1'b1;
    ihit   = 1'b0;
    #1;
    check("en_flush", {31'b0, flush}, 32'h1);
    step();
    idle();
    check("en_pc", imemaddr, 32'h60);
    redirect_to(32'h10);
    check("en_single_upd", {31'b0, pred_taken}, 32'h0);

    // Counter 01 -> 10 with new target, then 0x20 evicts 0x10 on index 0
    resolve(32'h10, 1'b1, 32'h70, 1'b0, 32'h0);
    step();
    idle();
    check("retarget_pc", imemaddr, 32'h70);
    redirect_to(32'h10);
    check("retarget_pred", {31'b0, pred_taken}, 32'h1);
    check("retarget_tgt", pred_target, 32'h70);
    resolve(32'h20, 1'b1, 32'h90, 1'b0, 32'h0);
    step();
    idle();
    check("evict_pc", imemaddr, 32'h90);
    redirect_to(32'h10);
    check("evict_pred", {31'b0, pred_taken}, 32'h0);

    // Sticky halt
    halt = 1'b1;
    ihit = 1'b1;
    step();
    halt = 1'b0;
    check("halt_ren", {31'b0, imemREN}, 32'h0);
    check("halt_pc", imemaddr, 32'h14);
    resolve(32'h10, 1'b1, 32'hA0, 1'b0, 32'h0);
    check("halt_flush", {31'b0, flush}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("halt_hold%0d", k), imemaddr, 32'h14);
    end
    check("halt_sticky", {31'b0, imemREN}, 32'h0);

    // Asynchronous reset in the middle of a pending redirect
    #2;
    nRST = 1'b0;
    #1;
    check("rst2_pc", imemaddr, 32'h0);
    check("rst2_ren", {31'b0, imemREN}, 32'h1);
    step();
    check("rst2_hold", imemaddr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
